// File: rtl/ultrasonic_ranging_scheduler.sv
// Round-robin scheduler that shares one echo-timing datapath across several ultrasonic rangers.
// Each slot runs trigger, echo measurement with timeout, a valid/ready result, then a ring-down gap.
module ultrasonic_ranging_scheduler #(
    parameter int unsigned NUM_SENSORS    = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned GAP_CYCLES     = 3000000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo_in,
    output logic [NUM_SENSORS-1:0] trig_out,
    output logic [CNT_W-1:0]       dist_data,
    output logic [CH_W-1:0]        dist_ch,
    output logic                   dist_timeout,
    output logic                   dist_vld,
    input  logic                   dist_rdy,
    output logic                   busy
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StTrig     = 3'd1;
    localparam logic [2:0] StWaitRise = 3'd2;
    localparam logic [2:0] StMeasure  = 3'd3;
    localparam logic [2:0] StReport   = 3'd4;
    localparam logic [2:0] StGap      = 3'd5;

    localparam logic [CNT_W-1:0] TrigLast    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;
    localparam logic [CH_W-1:0]  ChLast      = CH_W'(NUM_SENSORS - 1);
    localparam logic [NUM_SENSORS-1:0] TrigOne = NUM_SENSORS'(1);

    logic [2:0]             state_q, state_d;
    logic [CH_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       data_q, data_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   to_q, to_d;
    logic [NUM_SENSORS-1:0] echo_meta_q, echo_sync_q, echo_hist_q;

    logic                   echo_cur, echo_prev, echo_rise, echo_fall;
    logic [CNT_W-1:0]       timer_inc, count_inc;
    logic                   timer_expired;

    // Two-flop synchronizer plus a history stage for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            echo_hist_q <= '0;
        end else begin
            echo_meta_q <= echo_in;
            echo_sync_q <= echo_meta_q;
            echo_hist_q <= echo_sync_q;
        end
    end

    always_comb begin
        echo_cur      = echo_sync_q[ptr_q];
        echo_prev     = echo_hist_q[ptr_q];
        echo_rise     = echo_cur & ~echo_prev;
        echo_fall     = ~echo_cur & echo_prev;
        timer_inc     = (timer_q == CntMax) ? timer_q : timer_q + CNT_W'(1);
        count_inc     = (count_q == CntMax) ? count_q : count_q + CNT_W'(1);
        timer_expired = (timer_q == TimeoutLast);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        count_d = count_q;
        data_d  = data_q;
        ch_d    = ch_q;
        to_d    = to_q;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StTrig;
                    timer_d = '0;
                end
            end

            StTrig: begin
                if (timer_q == TrigLast) begin
                    state_d = StWaitRise;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end

            StWaitRise: begin
                timer_d = timer_inc;
                if (timer_expired) begin
                    data_d  = '1;
                    to_d    = 1'b1;
                    ch_d    = ptr_q;
                    state_d = StReport;
                end else if (echo_rise) begin
                    count_d = CNT_W'(1);
                    state_d = StMeasure;
                end
            end

            StMeasure: begin
                timer_d = timer_inc;
                // A fall on the last allowed cycle still yields a valid distance.
                if (echo_fall) begin
                    data_d  = count_q;
                    to_d    = 1'b0;
                    ch_d    = ptr_q;
                    state_d = StReport;
                end else if (timer_expired) begin
                    data_d  = '1;
                    to_d    = 1'b1;
                    ch_d    = ptr_q;
                    state_d = StReport;
                end else if (echo_cur) begin
                    count_d = count_inc;
                end
            end

            StReport: begin
                if (dist_rdy) begin
                    state_d = StGap;
                    timer_d = '0;
                end
            end

            StGap: begin
                if (timer_q == GapLast) begin
                    ptr_d   = (ptr_q == ChLast) ? '0 : ptr_q + CH_W'(1);
                    timer_d = '0;
                    state_d = enable ? StTrig : StIdle;
                end else begin
                    timer_d = timer_inc;
                end
            end

            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            timer_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            count_q <= count_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            to_q    <= to_d;
        end
    end

    // Decoded from registered state so reset clears them without waiting for a clock.
    always_comb begin
        trig_out     = (state_q == StTrig) ? (TrigOne << ptr_q) : '0;
        dist_vld     = (state_q == StReport);
        busy         = (state_q != StIdle);
        dist_data    = data_q;
        dist_ch      = ch_q;
        dist_timeout = to_q;
    end

endmodule

// File: tb/tb_ultrasonic_ranging_scheduler.sv
// Randomized/directed bench for ultrasonic_ranging_scheduler with scaled-down timing parameters.
// Expected results come from a slot-level model: echo pulse position/width versus the timeout window.
module tb_ultrasonic_ranging_scheduler;

    localparam int unsigned NS    = 4;
    localparam int unsigned CHW   = 2;
    localparam int unsigned TRIG  = 20;
    localparam int unsigned TMO   = 400;
    localparam int unsigned GAP   = 60;
    localparam int unsigned CW    = 22;
    localparam int          BOUND = 3000;
    localparam logic [CW-1:0] ALL1 = '1;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          enable = 1'b0;
    logic [NS-1:0] echo_in = '0;
    logic [NS-1:0] trig_out;
    logic [CW-1:0] dist_data;
    logic [CHW-1:0] dist_ch;
    logic          dist_timeout;
    logic          dist_vld;
    logic          dist_rdy = 1'b1;
    logic          busy;

    int ntests = 0;
    int nfail  = 0;
    int exp_ptr = 0;

    ultrasonic_ranging_scheduler #(
        .NUM_SENSORS   (NS),
        .CH_W          (CHW),
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .CNT_W         (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .echo_in     (echo_in),
        .trig_out    (trig_out),
        .dist_data   (dist_data),
        .dist_ch     (dist_ch),
        .dist_timeout(dist_timeout),
        .dist_vld    (dist_vld),
        .dist_rdy    (dist_rdy),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Active sensor pulses high from cycle k for p cycles after trigger end; other sensors
    // see random noise. keep_en=0 drops enable during the slot; hold>0 stalls dist_rdy.
    task automatic run_slot(input int k, input int p, input bit echo_en, input int hold,
                            input bit keep_en);
        int n;
        int fall_i;
        int exp_lat;
        int bad;
        bit exp_to;
        logic [CW-1:0] exp_data;
        logic [NS-1:0] onehot;
        logic [NS-1:0] noise;

        dist_rdy = (hold == 0);
        onehot = NS'(1) << exp_ptr;
        n = 0;
        while (trig_out == '0 && n < BOUND) begin tick(); n++; end
        check("trig_onehot", 32'(trig_out), 32'(onehot));
        if (!keep_en) enable = 1'b0;
        n = 0;
        while (trig_out != '0 && n < BOUND) begin tick(); n++; end
        check("trig_width", 32'(n), 32'(TRIG));

        // Edge reaches the decision logic 3 cycles after the pin changes.
        fall_i   = k + p + 2;
        exp_to   = !(echo_en && fall_i <= int'(TMO) - 1);
        exp_data = exp_to ? ALL1 : CW'(p);
        exp_lat  = exp_to ? int'(TMO) : fall_i + 1;

        n = 0;
        while (!dist_vld && n < BOUND) begin
            noise = NS'($urandom) & ~onehot;
            echo_in = (echo_en && n >= k && n < k + p) ? (noise | onehot) : noise;
            tick();
            n++;
        end
        echo_in = '0;
        check("result_latency", 32'(n), 32'(exp_lat));
        check("dist_data", 32'(dist_data), 32'(exp_data));
        check("dist_ch", 32'(dist_ch), 32'(exp_ptr));
        check("dist_timeout", 32'(dist_timeout), 32'(exp_to));

        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (dist_vld !== 1'b1 || dist_data !== exp_data || trig_out !== '0 ||
                    dist_ch !== CHW'(exp_ptr) || dist_timeout !== exp_to) bad++;
            end
            check("hold_stable_violations", 32'(bad), 32'd0);
            dist_rdy = 1'b1;
        end
        tick();
        check("vld_after_xfer", 32'(dist_vld), 32'd0);
        exp_ptr = (exp_ptr + 1) % NS;

        if (keep_en) begin
            n = 0;
            while (trig_out == '0 && n < BOUND) begin tick(); n++; end
            check("gap_len", 32'(n), 32'(GAP));
        end else begin
            repeat (GAP + 2) tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_trig", 32'(trig_out), 32'd0);
            enable = 1'b1;
        end
    endtask

    initial begin
        int n;
        int rk;
        int rp;

        #3;
        check("rst_async_trig", 32'(trig_out), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("rst_vld", 32'(dist_vld), 32'd0);
        check("rst_data", 32'(dist_data), 32'd0);
        check("rst_ch", 32'(dist_ch), 32'd0);
        check("rst_timeout", 32'(dist_timeout), 32'd0);
        sys_rst = 1'b0;
        tick();
        check("idle_no_enable_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        // Sensor 0 nominal measurement.
        run_slot(20, 150, 1'b1, 0, 1'b1);
        // Round robin with increasing widths: ch 1,2,3,0,1.
        for (int i = 0; i < 5; i++) run_slot(10 + i, 40 * (i + 1), 1'b1, 0, 1'b1);
        // Silent sensor 2 times out.
        run_slot(0, 0, 1'b0, 0, 1'b1);
        // Consumer stall on sensor 3.
        run_slot(15, 77, 1'b1, 50, 1'b1);
        // Fall exactly on the last allowed cycle, then one cycle too late.
        run_slot(5, int'(TMO) - 3 - 5, 1'b1, 0, 1'b1);
        run_slot(5, int'(TMO) - 2 - 5, 1'b1, 0, 1'b1);
        // Echo never falls inside the window.
        run_slot(30, 1000, 1'b1, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rk = int'($urandom_range(0, 40));
            rp = int'($urandom_range(1, 420));
            run_slot(rk, rp, 1'b1, int'($urandom_range(0, 3)), 1'b1);
        end

        // Enable dropped mid-slot: slot completes, then idles; restart resumes at next sensor.
        run_slot(8, 60, 1'b1, 0, 1'b0);
        run_slot(12, 90, 1'b1, 0, 1'b1);

        // Reset during MEASURE.
        n = 0;
        while (trig_out == '0 && n < BOUND) begin tick(); n++; end
        while (trig_out != '0 && n < BOUND) begin tick(); n++; end
        echo_in = NS'(1) << exp_ptr;
        repeat (12) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #3;
        sys_rst = 1'b1;
        #1;
        check("mid_rst_trig", 32'(trig_out), 32'd0);
        check("mid_rst_vld", 32'(dist_vld), 32'd0);
        check("mid_rst_data", 32'(dist_data), 32'd0);
        check("mid_rst_ch", 32'(dist_ch), 32'd0);
        check("mid_rst_timeout", 32'(dist_timeout), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        echo_in = '0;
        repeat (4) tick();
        sys_rst = 1'b0;
        exp_ptr = 0;
        run_slot(25, 33, 1'b1, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
